// File: rtl/nb_score_accumulator.sv
// Per-message saturating score accumulator for the ham/spam classifier.
// Sums per-word class products and presents the scores and decision through a valid/ready handshake.
module nb_score_accumulator #(
    parameter int PROD_W = 36,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [PROD_W-1:0] ham_prod,
    input  logic [PROD_W-1:0] spam_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_spam,
    output logic [ACC_W-1:0]  out_ham_score,
    output logic [ACC_W-1:0]  out_spam_score,
    output logic [CNT_W-1:0]  out_word_cnt,
    output logic              out_sat
);

    // state    | meaning
    // ST_ACCUM | accepting beats, accumulating the current message
    // ST_DONE  | result frozen and offered downstream until out_ready
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   ham_acc_q, ham_acc_d;
    logic [ACC_W-1:0]   spam_acc_q, spam_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               is_spam_q, is_spam_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W:0]     ham_sum, spam_sum;
    logic [ACC_W-1:0]   ham_next, spam_next;
    logic               ham_clamp, spam_clamp, cnt_full;

    // One extra bit of sum width: its carry-out is exactly the overflow condition.
    always_comb begin
        ham_sum    = {1'b0, ham_acc_q}  + {{(ACC_W+1-PROD_W){1'b0}}, ham_prod};
        spam_sum   = {1'b0, spam_acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, spam_prod};
        ham_clamp  = ham_sum[ACC_W];
        spam_clamp = spam_sum[ACC_W];
        ham_next   = ham_clamp  ? ACC_MAX : ham_sum[ACC_W-1:0];
        spam_next  = spam_clamp ? ACC_MAX : spam_sum[ACC_W-1:0];
        cnt_full   = &cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        ham_acc_d  = ham_acc_q;
        spam_acc_d = spam_acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        is_spam_d  = is_spam_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    ham_acc_d  = ham_next;
                    spam_acc_d = spam_next;
                    cnt_d      = cnt_full ? cnt_q : cnt_q + CNT_ONE;
                    sat_d      = sat_q | ham_clamp | spam_clamp | cnt_full;
                    if (in_last) begin
                        state_d   = ST_DONE;
                        is_spam_d = (spam_next > ham_next);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d    = ST_ACCUM;
                    ham_acc_d  = '0;
                    spam_acc_d = '0;
                    cnt_d      = '0;
                    sat_d      = 1'b0;
                    is_spam_d  = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            ham_acc_q   <= '0;
            spam_acc_q  <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            is_spam_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ham_acc_q   <= ham_acc_d;
            spam_acc_q  <= spam_acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            is_spam_q   <= is_spam_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_is_spam    = is_spam_q;
    assign out_ham_score  = ham_acc_q;
    assign out_spam_score = spam_acc_q;
    assign out_word_cnt   = cnt_q;
    assign out_sat        = sat_q;

endmodule

// File: tb/tb_nb_score_accumulator.sv
// Self-checking bench for nb_score_accumulator against a plain-arithmetic message model.
module tb_nb_score_accumulator;
    localparam int PW = 36;
    localparam int AW = 40;
    localparam int CW = 8;
    localparam logic [63:0] ACC_MAX = (64'd1 << AW) - 64'd1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [PW-1:0] ham_prod = '0;
    logic [PW-1:0] spam_prod = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_is_spam;
    logic [AW-1:0] out_ham_score;
    logic [AW-1:0] out_spam_score;
    logic [CW-1:0] out_word_cnt;
    logic          out_sat;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_ham, m_spam;
    int          m_cnt;
    bit          m_sat;

    always #5 clk = ~clk;

    nb_score_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .ham_prod(ham_prod), .spam_prod(spam_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_spam(out_is_spam),
        .out_ham_score(out_ham_score), .out_spam_score(out_spam_score),
        .out_word_cnt(out_word_cnt), .out_sat(out_sat)
    );

    task automatic m_clear();
        m_ham = 0; m_spam = 0; m_cnt = 0; m_sat = 0;
    endtask

    task automatic m_beat(input logic [63:0] h, input logic [63:0] s);
        m_ham = m_ham + h;
        if (m_ham > ACC_MAX) begin m_ham = ACC_MAX; m_sat = 1; end
        m_spam = m_spam + s;
        if (m_spam > ACC_MAX) begin m_spam = ACC_MAX; m_sat = 1; end
        if (m_cnt == CNT_MAX) m_sat = 1;
        else m_cnt = m_cnt + 1;
    endtask

    function automatic logic [90:0] exp_vec();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {1'b1, (m_spam > m_ham), m_sat, c, m_ham[AW-1:0], m_spam[AW-1:0]};
    endfunction

    function automatic logic [90:0] got_vec();
        return {out_valid, out_is_spam, out_sat, out_word_cnt, out_ham_score, out_spam_score};
    endfunction

    function automatic logic [PW-1:0] rand_prod();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 1) == 1) r = r & 64'hFFFF;
        return r[PW-1:0];
    endfunction

    task automatic send_beat(input logic [PW-1:0] h, input logic [PW-1:0] s, input logic last);
        @(negedge clk);
        in_valid = 1'b1; ham_prod = h; spam_prod = s; in_last = last;
        m_beat({28'd0, h}, {28'd0, s});
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({in_ready, got_vec()} !== {1'b1, 91'd0})
            $display("FAIL reset_values got=%h exp=%h", {in_ready, got_vec()}, {1'b1, 91'd0});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        m_clear();
        send_beat(36'd100, 36'd50, 1'b0);
        send_beat(36'd200, 36'd60, 1'b0);
        send_beat(36'd300, 36'd70, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (got_vec() !== {1'b1, 1'b0, 1'b0, 8'd3, 40'd600, 40'd180}) begin
            n_errors++;
            $display("FAIL basic_result got=%h exp=%h", got_vec(), {1'b1, 1'b0, 1'b0, 8'd3, 40'd600, 40'd180});
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, out_word_cnt, out_ham_score} !== {1'b0, 1'b1, 8'd0, 40'd0}) begin
            n_errors++;
            $display("FAIL basic_one_cycle got=%h exp=%h", {out_valid, in_ready, out_word_cnt, out_ham_score},
                     {1'b0, 1'b1, 8'd0, 40'd0});
        end
    endtask

    task automatic test_spam_tie();
        out_ready = 1'b1;
        m_clear();
        send_beat(36'd10, 36'd11, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (got_vec() !== exp_vec() || out_is_spam !== 1'b1) begin
            n_errors++;
            $display("FAIL spam_result got=%h exp=%h", got_vec(), exp_vec());
        end
        m_clear();
        send_beat(36'd5, 36'd5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (got_vec() !== {1'b1, 1'b0, 1'b0, 8'd1, 40'd5, 40'd5}) begin
            n_errors++;
            $display("FAIL tie_result got=%h exp=%h", got_vec(), {1'b1, 1'b0, 1'b0, 8'd1, 40'd5, 40'd5});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [90:0] held;
        logic [PW-1:0] dh, ds;
        out_ready = 1'b0;
        m_clear();
        send_beat(rand_prod(), rand_prod(), 1'b0);
        send_beat(rand_prod(), rand_prod(), 1'b1);
        @(negedge clk);
        held = exp_vec();
        n_checks++;
        if (got_vec() !== held) begin
            n_errors++;
            $display("FAIL bp_result got=%h exp=%h", got_vec(), held);
        end
        dh = rand_prod(); ds = rand_prod();
        in_valid = 1'b1; in_last = 1'b1; ham_prod = dh; spam_prod = ds;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, got_vec()} !== {1'b0, held}) begin
                n_errors++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {in_ready, got_vec()}, {1'b0, held});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_word_cnt, out_ham_score, out_spam_score} !== {1'b1, 1'b0, 88'd0}) begin
            n_errors++;
            $display("FAIL bp_handshake got=%h exp=%h",
                     {in_ready, out_valid, out_word_cnt, out_ham_score, out_spam_score}, {1'b1, 1'b0, 88'd0});
        end
        m_clear();
        m_beat({28'd0, dh}, {28'd0, ds});
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (got_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL bp_next_msg got=%h exp=%h", got_vec(), exp_vec());
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int len;
        for (int m = 0; m < 10; m++) begin
            len = $urandom_range(1, 6);
            out_ready = ($urandom_range(0, 1) == 1);
            m_clear();
            for (int b = 0; b < len; b++) send_beat(rand_prod(), rand_prod(), (b == len - 1));
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            n_checks++;
            if ({in_ready, got_vec()} !== {1'b0, exp_vec()}) begin
                n_errors++;
                $display("FAIL rand_msg[%0d] got=%h exp=%h", m, {in_ready, got_vec()}, {1'b0, exp_vec()});
            end
            if (!out_ready) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                out_ready = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, out_word_cnt} !== {1'b1, 1'b0, 8'd0}) begin
                n_errors++;
                $display("FAIL rand_release[%0d] got=%h exp=%h", m, {in_ready, out_valid, out_word_cnt},
                         {1'b1, 1'b0, 8'd0});
            end
        end
    endtask

    task automatic test_sat_acc();
        out_ready = 1'b1;
        m_clear();
        for (int b = 0; b < 20; b++) send_beat({PW{1'b1}}, 36'd3, (b == 19));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (got_vec() !== exp_vec() || out_ham_score !== {AW{1'b1}} || out_spam_score !== 40'd60 || out_sat !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_acc got=%h exp=%h", got_vec(), exp_vec());
        end
        @(negedge clk);
    endtask

    task automatic test_sat_cnt();
        out_ready = 1'b1;
        m_clear();
        for (int b = 0; b < 300; b++) send_beat(36'd1, 36'd1, (b == 299));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (got_vec() !== {1'b1, 1'b0, 1'b1, 8'd255, 40'd300, 40'd300}) begin
            n_errors++;
            $display("FAIL sat_cnt got=%h exp=%h", got_vec(), {1'b1, 1'b0, 1'b1, 8'd255, 40'd300, 40'd300});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        m_clear();
        send_beat(rand_prod(), rand_prod(), 1'b0);
        send_beat(rand_prod(), rand_prod(), 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, got_vec()} !== {1'b1, 91'd0}) begin
            n_errors++;
            $display("FAIL async_reset got=%h exp=%h", {in_ready, got_vec()}, {1'b1, 91'd0});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        send_beat(36'd7, 36'd9, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (got_vec() !== {1'b1, 1'b1, 1'b0, 8'd1, 40'd7, 40'd9}) begin
            n_errors++;
            $display("FAIL after_reset got=%h exp=%h", got_vec(), {1'b1, 1'b1, 1'b0, 8'd1, 40'd7, 40'd9});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spam_tie();
        test_backpressure();
        test_random();
        test_sat_acc();
        test_sat_cnt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
